// File: rtl/conv_mem_pkg.sv
// Shared encodings and defaults for the CONV layer-buffer memory responder.
package conv_mem_pkg;

  localparam int DW_DEF        = 5;
  localparam int AW_DEF        = 4;
  localparam int IMG_DEPTH_DEF = 16;
  localparam int L0_DEPTH_DEF  = 16;
  localparam int L1_DEPTH_DEF  = 4;
  localparam int L2_DEPTH_DEF  = 8;
  localparam int NUM_BANKS     = 6;

  typedef enum logic [2:0] {
    SEL_IMG  = 3'd0,
    SEL_L0_0 = 3'd1,
    SEL_L0_1 = 3'd2,
    SEL_L1_0 = 3'd3,
    SEL_L1_1 = 3'd4,
    SEL_L2   = 3'd5
  } csel_e;

  // Layer bit in wr_seen owned by a writable bank.
  function automatic logic [1:0] seen_idx(input logic [2:0] sel);
    case (sel)
      SEL_L0_0, SEL_L0_1: seen_idx = 2'd0;
      SEL_L1_0, SEL_L1_1: seen_idx = 2'd1;
      default:            seen_idx = 2'd2;
    endcase
  endfunction

endpackage

// File: rtl/conv_mem_bank_ram.sv
// One layer bank: a write port and two registered read ports that return 0 out of range.
module conv_mem_bank_ram #(
  parameter int DEPTH = 16,
  parameter int DW    = 5,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re_a,
  input  logic [AW-1:0] raddr_a,
  output logic [DW-1:0] rdata_a,
  input  logic          re_b,
  input  logic [AW-1:0] raddr_b,
  output logic [DW-1:0] rdata_b
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] mem_d [DEPTH];
  logic [DW-1:0] rdata_a_q, rdata_a_d;
  logic [DW-1:0] rdata_b_q, rdata_b_d;

  function automatic logic in_range(input logic [AW-1:0] a);
    return {1'b0, a} < (AW+1)'(DEPTH);
  endfunction

  // Reads use mem_q, so a same-cycle write to the word is seen only on the next read.
  always_comb begin
    mem_d     = mem_q;
    rdata_a_d = rdata_a_q;
    rdata_b_d = rdata_b_q;
    if (we && in_range(waddr)) mem_d[waddr[IW-1:0]] = wdata;
    if (re_a) rdata_a_d = in_range(raddr_a) ? mem_q[raddr_a[IW-1:0]] : '0;
    if (re_b) rdata_b_d = in_range(raddr_b) ? mem_q[raddr_b[IW-1:0]] : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      rdata_a_q <= '0;
      rdata_b_q <= '0;
    end else begin
      mem_q     <= mem_d;
      rdata_a_q <= rdata_a_d;
      rdata_b_q <= rdata_b_d;
    end
  end

  assign rdata_a = rdata_a_q;
  assign rdata_b = rdata_b_q;

endmodule

// File: rtl/conv_mem_responder.sv
// CONV layer-buffer responder: six banks, host image load, host readback, per-layer write flags.
module conv_mem_responder
  import conv_mem_pkg::*;
#(
  parameter int DW        = DW_DEF,
  parameter int AW        = AW_DEF,
  parameter int IMG_DEPTH = IMG_DEPTH_DEF,
  parameter int L0_DEPTH  = L0_DEPTH_DEF,
  parameter int L1_DEPTH  = L1_DEPTH_DEF,
  parameter int L2_DEPTH  = L2_DEPTH_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          busy,
  input  logic          crd,
  input  logic [2:0]    csel,
  input  logic [AW-1:0] caddr_rd,
  output logic [DW-1:0] cdata_rd,
  input  logic          cwr,
  input  logic [AW-1:0] caddr_wr,
  input  logic [DW-1:0] cdata_wr,
  input  logic          ld_en,
  input  logic [AW-1:0] ld_addr,
  input  logic [DW-1:0] ld_data,
  output logic          ld_err,
  input  logic          dbg_rd,
  input  logic [2:0]    dbg_sel,
  input  logic [AW-1:0] dbg_addr,
  output logic [DW-1:0] dbg_data,
  output logic [2:0]    wr_seen
);

  function automatic int sel_depth(input logic [2:0] s);
    case (s)
      SEL_IMG:            sel_depth = IMG_DEPTH;
      SEL_L0_0, SEL_L0_1: sel_depth = L0_DEPTH;
      SEL_L1_0, SEL_L1_1: sel_depth = L1_DEPTH;
      default:            sel_depth = L2_DEPTH;
    endcase
  endfunction

  logic [DW-1:0] crd_bank [NUM_BANKS];
  logic [DW-1:0] dbg_bank [NUM_BANKS];

  logic          busy_q, busy_d;
  logic          ld_err_q, ld_err_d;
  logic [2:0]    wr_seen_q, wr_seen_d;
  logic [2:0]    rd_sel_q, rd_sel_d;
  logic [2:0]    dbg_sel_q, dbg_sel_d;
  logic          cwr_ok;

  for (genvar g = 0; g < NUM_BANKS; g++) begin : g_bank
    localparam int D = (g == 0) ? IMG_DEPTH :
                       (g <  3) ? L0_DEPTH  :
                       (g <  5) ? L1_DEPTH  : L2_DEPTH;
    logic          we;
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;

    // The image bank's only write port is the host load; CONV cannot write it.
    if (g == 0) begin : g_img
      assign we = ld_en & ~busy;
      assign wa = ld_addr;
      assign wd = ld_data;
    end else begin : g_layer
      assign we = cwr & (csel == 3'(g));
      assign wa = caddr_wr;
      assign wd = cdata_wr;
    end

    conv_mem_bank_ram #(.DEPTH(D), .DW(DW), .AW(AW)) u_ram (
      .clk     (clk),
      .reset   (reset),
      .we      (we),
      .waddr   (wa),
      .wdata   (wd),
      .re_a    (crd & (csel == 3'(g))),
      .raddr_a (caddr_rd),
      .rdata_a (crd_bank[g]),
      .re_b    (dbg_rd & (dbg_sel == 3'(g))),
      .raddr_b (dbg_addr),
      .rdata_b (dbg_bank[g])
    );
  end

  // Each bank holds its last read; the registered select picks which one is current.
  always_comb begin
    busy_d    = busy;
    ld_err_d  = ld_en & busy;
    rd_sel_d  = crd    ? csel    : rd_sel_q;
    dbg_sel_d = dbg_rd ? dbg_sel : dbg_sel_q;
    cwr_ok    = cwr && (csel >= SEL_L0_0) && (csel <= SEL_L2) &&
                ({1'b0, caddr_wr} < (AW+1)'(sel_depth(csel)));
    wr_seen_d = wr_seen_q;
    if (busy && !busy_q) wr_seen_d = '0;
    if (cwr_ok) wr_seen_d[seen_idx(csel)] = 1'b1;
  end

  always_comb begin
    cdata_rd = '0;
    dbg_data = '0;
    for (int unsigned i = 0; i < NUM_BANKS; i++) begin
      if (rd_sel_q  == 3'(i)) cdata_rd = crd_bank[i];
      if (dbg_sel_q == 3'(i)) dbg_data = dbg_bank[i];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q    <= 1'b0;
      ld_err_q  <= 1'b0;
      wr_seen_q <= '0;
      rd_sel_q  <= '0;
      dbg_sel_q <= '0;
    end else begin
      busy_q    <= busy_d;
      ld_err_q  <= ld_err_d;
      wr_seen_q <= wr_seen_d;
      rd_sel_q  <= rd_sel_d;
      dbg_sel_q <= dbg_sel_d;
    end
  end

  assign ld_err  = ld_err_q;
  assign wr_seen = wr_seen_q;

endmodule

// File: tb/tb_conv_mem_responder.sv
// Directed plus random bench for conv_mem_responder against a bank-array reference model.
module tb_conv_mem_responder;

  logic       clk = 1'b0;
  logic       reset, busy, crd, cwr, ld_en, dbg_rd;
  logic [2:0] csel, dbg_sel;
  logic [3:0] caddr_rd, caddr_wr, ld_addr, dbg_addr;
  logic [4:0] cdata_wr, ld_data;
  logic [4:0] cdata_rd, dbg_data;
  logic       ld_err;
  logic [2:0] wr_seen;

  int n_checks = 0;
  int n_fail   = 0;

  logic [4:0] mem [6][16];
  int         dep [6] = '{16, 16, 16, 4, 4, 8};
  logic [4:0] exp_cdata, exp_dbg;
  logic       exp_ld_err, m_busy_d;
  logic [2:0] exp_seen;

  conv_mem_responder #(
    .DW(5), .AW(4), .IMG_DEPTH(16), .L0_DEPTH(16), .L1_DEPTH(4), .L2_DEPTH(8)
  ) dut (
    .clk(clk), .reset(reset), .busy(busy),
    .crd(crd), .csel(csel), .caddr_rd(caddr_rd), .cdata_rd(cdata_rd),
    .cwr(cwr), .caddr_wr(caddr_wr), .cdata_wr(cdata_wr),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data), .ld_err(ld_err),
    .dbg_rd(dbg_rd), .dbg_sel(dbg_sel), .dbg_addr(dbg_addr), .dbg_data(dbg_data),
    .wr_seen(wr_seen)
  );

  always #5 clk = ~clk;

  function automatic logic [4:0] peek(input logic [2:0] s, input logic [3:0] a);
    if (s > 3'd5) return 5'd0;
    if (int'(a) >= dep[s]) return 5'd0;
    return mem[s][a];
  endfunction

  // Apply one clock edge to the model using the inputs currently driven.
  task automatic model_edge();
    if (reset) begin
      for (int b = 0; b < 6; b++) for (int a = 0; a < 16; a++) mem[b][a] = 5'd0;
      exp_cdata = 0; exp_dbg = 0; exp_ld_err = 0; exp_seen = 0; m_busy_d = 0;
      return;
    end
    if (crd)    exp_cdata = peek(csel, caddr_rd);
    if (dbg_rd) exp_dbg   = peek(dbg_sel, dbg_addr);
    exp_ld_err = ld_en && busy;
    if (busy && !m_busy_d) exp_seen = 3'b000;
    if (cwr && csel >= 1 && csel <= 5 && int'(caddr_wr) < dep[csel]) begin
      exp_seen[(int'(csel) - 1) / 2] = 1'b1;
      mem[csel][caddr_wr] = cdata_wr;
    end
    if (ld_en && !busy) mem[0][ld_addr] = ld_data;
    m_busy_d = busy;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
    chk("cdata_rd", {3'b0, cdata_rd}, {3'b0, exp_cdata});
    chk("dbg_data", {3'b0, dbg_data}, {3'b0, exp_dbg});
    chk("ld_err",   {7'b0, ld_err},   {7'b0, exp_ld_err});
    chk("wr_seen",  {5'b0, wr_seen},  {5'b0, exp_seen});
  endtask

  task automatic idle();
    crd = 0; cwr = 0; ld_en = 0; dbg_rd = 0;
  endtask

  initial begin
    reset = 1; busy = 0; idle();
    csel = 0; dbg_sel = 0; caddr_rd = 0; caddr_wr = 0; ld_addr = 0; dbg_addr = 0;
    cdata_wr = 0; ld_data = 0;
    #2;
    tick();
    reset = 0;
    chk("reset_seen", {5'b0, wr_seen}, 8'h00);
    chk("reset_cdata", {3'b0, cdata_rd}, 8'h00);

    for (int i = 0; i < 16; i++) begin
      ld_en = 1; ld_addr = 4'(i); ld_data = 5'(i);
      tick();
    end
    idle();
    crd = 1; csel = 0; caddr_rd = 7;
    tick(); idle();
    chk("img7", {3'b0, cdata_rd}, 8'h07);

    busy = 1; tick();
    cwr = 1; csel = 1; caddr_wr = 3; cdata_wr = 5'h15;
    tick(); idle();
    chk("seen_l0", {5'b0, wr_seen}, 8'h01);
    crd = 1; csel = 1; caddr_rd = 3;
    tick();
    chk("l0_rd", {3'b0, cdata_rd}, 8'h15);
    cwr = 1; caddr_wr = 3; cdata_wr = 5'h0A;
    tick(); idle();
    chk("rbw_old", {3'b0, cdata_rd}, 8'h15);
    crd = 1; tick(); idle();
    chk("rbw_new", {3'b0, cdata_rd}, 8'h0A);

    cwr = 1; csel = 4; caddr_wr = 5; cdata_wr = 5'h1F; tick();
    csel = 6; caddr_wr = 0; tick(); idle();
    chk("drop_seen", {5'b0, wr_seen}, 8'h01);
    crd = 1; csel = 4; caddr_rd = 5; tick(); idle();
    chk("oor_rd", {3'b0, cdata_rd}, 8'h00);

    ld_en = 1; ld_addr = 2; ld_data = 5'h11; tick(); idle();
    chk("ld_err_pulse", {7'b0, ld_err}, 8'h01);
    tick();
    chk("ld_err_clear", {7'b0, ld_err}, 8'h00);
    cwr = 1; csel = 5; caddr_wr = 7; cdata_wr = 5'h13; tick(); idle();
    busy = 0; tick();
    dbg_rd = 1; dbg_sel = 5; dbg_addr = 7; tick();
    chk("dbg_l2", {3'b0, dbg_data}, 8'h13);
    dbg_sel = 0; dbg_addr = 2; tick(); idle();
    chk("img2_kept", {3'b0, dbg_data}, 8'h02);

    busy = 1; tick();
    reset = 1; cwr = 1; csel = 5; caddr_wr = 0; cdata_wr = 5'h09; tick();
    reset = 0; idle();
    chk("rst_seen", {5'b0, wr_seen}, 8'h00);
    chk("rst_cdata", {3'b0, cdata_rd}, 8'h00);
    dbg_rd = 1; dbg_sel = 5; dbg_addr = 0; tick(); idle();
    chk("rst_dbg", {3'b0, dbg_data}, 8'h00);

    busy = 0; tick();
    for (int s = 1; s <= 5; s += 2) begin
      cwr = 1; csel = 3'(s); caddr_wr = 1; cdata_wr = 5'(s); tick();
    end
    idle();
    chk("seen_all", {5'b0, wr_seen}, 8'h07);
    busy = 1; cwr = 1; csel = 3; caddr_wr = 1; cdata_wr = 5'h04; tick(); idle();
    chk("seen_edge", {5'b0, wr_seen}, 8'h02);

    for (int n = 0; n < 600; n++) begin
      reset    = ($urandom_range(0, 99) < 2);
      busy     = ($urandom_range(0, 9) < 6);
      crd      = $urandom_range(0, 1);
      cwr      = $urandom_range(0, 1);
      ld_en    = ($urandom_range(0, 3) == 0);
      dbg_rd   = $urandom_range(0, 1);
      csel     = 3'($urandom_range(0, 7));
      dbg_sel  = 3'($urandom_range(0, 7));
      caddr_rd = 4'($urandom);
      caddr_wr = 4'($urandom);
      ld_addr  = 4'($urandom);
      dbg_addr = 4'($urandom);
      cdata_wr = 5'($urandom);
      ld_data  = 5'($urandom);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
